// File: rtl/spoc_bdi_block_buffer_if.sv
// Handshake bundle between a bdi word source and the block buffer, and between
// the block buffer and the permutation datapath.
interface spoc_bdi_block_buffer_if #(
    parameter int PW   = 32,
    parameter int RATE = 64
);
    localparam int SB = $clog2(PW / 8) + 1;
    localparam int BB = $clog2(RATE / 8) + 1;

    logic [PW-1:0]   bdi;
    logic            bdi_valid;
    logic            bdi_ready;
    logic [SB-1:0]   bdi_size;
    logic            bdi_eot;
    logic            pad_empty;
    logic [RATE-1:0] blk;
    logic            blk_valid;
    logic            blk_ready;
    logic            blk_partial;
    logic [BB-1:0]   blk_bytes;
    logic [RATE-1:0] blk_mask;

    modport slave (
        input  bdi, bdi_valid, bdi_size, bdi_eot, pad_empty, blk_ready,
        output bdi_ready, blk, blk_valid, blk_partial, blk_bytes, blk_mask
    );

    modport master (
        output bdi, bdi_valid, bdi_size, bdi_eot, pad_empty, blk_ready,
        input  bdi_ready, blk, blk_valid, blk_partial, blk_bytes, blk_mask
    );
endinterface

// File: rtl/spoc_bdi_block_buffer.sv
// Assembles PW-bit bdi words into one RATE-bit block, zeroing invalid bytes,
// applying 0x80/zero padding and producing a byte-valid mask for truncation.
module spoc_bdi_block_buffer #(
    parameter int PW   = 32,
    parameter int RATE = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    spoc_bdi_block_buffer_if.slave bus
);
    localparam int NW = RATE / PW;
    localparam int NB = RATE / 8;
    localparam int WB = PW / 8;
    localparam int SB = $clog2(WB) + 1;
    localparam int BB = $clog2(NB) + 1;
    localparam int IW = $clog2(NW);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BB-1:0]   cum_q, cum_d;
    logic [RATE-1:0] blk_q, blk_d;
    logic [RATE-1:0] mask_q, mask_d;
    logic [BB-1:0]   bytes_q, bytes_d;
    logic            partial_q, partial_d;

    logic [BB-1:0]   cum_new;
    logic [PW-1:0]   word_z;
    logic [RATE-1:0] word_pos;
    logic [RATE-1:0] mask_new;
    logic [RATE-1:0] pad_new;
    logic            accept;
    logic            close;
    logic            empty_req;

    assign bus.bdi_ready   = (state_q == FILL) & ~rst;
    assign bus.blk_valid   = (state_q == HOLD);
    assign bus.blk         = blk_q;
    assign bus.blk_mask    = mask_q;
    assign bus.blk_bytes   = bytes_q;
    assign bus.blk_partial = partial_q;

    assign accept    = bus.bdi_valid & bus.bdi_ready;
    assign close     = bus.bdi_eot | (bus.bdi_size < SB'(WB)) | (idx_q == IW'(NW - 1));
    assign empty_req = (state_q == FILL) & (idx_q == '0) & ~bus.bdi_valid & bus.pad_empty;
    assign cum_new   = cum_q + BB'(bus.bdi_size);

    // Byte k of the word (k = 0 is the MSB byte) survives only if k < bdi_size.
    genvar gi;
    generate
        for (gi = 0; gi < WB; gi++) begin : g_word_zero
            assign word_z[PW-1-8*gi -: 8] = (SB'(gi) < bus.bdi_size) ? bus.bdi[PW-1-8*gi -: 8] : 8'h00;
        end
        for (gi = 0; gi < NB; gi++) begin : g_blk_byte
            assign mask_new[RATE-1-8*gi -: 8] = (cum_new > BB'(gi))  ? 8'hFF : 8'h00;
            assign pad_new[RATE-1-8*gi -: 8]  = (cum_new == BB'(gi)) ? 8'h80 : 8'h00;
        end
    endgenerate

    // Slots beyond idx are still zero, so OR-ing the shifted word in is enough.
    assign word_pos = {word_z, {(RATE - PW){1'b0}}} >> (32'(idx_q) * PW);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cum_d     = cum_q;
        blk_d     = blk_q;
        mask_d    = mask_q;
        bytes_d   = bytes_q;
        partial_d = partial_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    blk_d  = blk_q | word_pos;
                    mask_d = mask_new;
                    cum_d  = cum_new;
                    idx_d  = idx_q + IW'(1);
                    if (close) begin
                        blk_d     = blk_q | word_pos | pad_new;
                        bytes_d   = cum_new;
                        partial_d = (cum_new < BB'(NB));
                        state_d   = HOLD;
                    end
                end else if (empty_req) begin
                    blk_d     = {8'h80, {(RATE - 8){1'b0}}};
                    mask_d    = '0;
                    bytes_d   = '0;
                    partial_d = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.blk_ready) begin
                    blk_d     = '0;
                    mask_d    = '0;
                    cum_d     = '0;
                    idx_d     = '0;
                    bytes_d   = '0;
                    partial_d = 1'b0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= '0;
            cum_q     <= '0;
            blk_q     <= '0;
            mask_q    <= '0;
            bytes_q   <= '0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cum_q     <= cum_d;
            blk_q     <= blk_d;
            mask_q    <= mask_d;
            bytes_q   <= bytes_d;
            partial_q <= partial_d;
        end
    end
endmodule

// File: tb/tb_spoc_bdi_block_buffer.sv
// Scoreboard bench for spoc_bdi_block_buffer in three configurations:
// PW32/RATE64 (dut0), PW32/RATE128 (dut1) and PW8/RATE64 (dut2).
module tb_spoc_bdi_block_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    spoc_bdi_block_buffer_if #(.PW(32), .RATE(64))  b64 ();
    spoc_bdi_block_buffer_if #(.PW(32), .RATE(128)) b128 ();
    spoc_bdi_block_buffer_if #(.PW(8),  .RATE(64))  b8 ();

    spoc_bdi_block_buffer #(.PW(32), .RATE(64))  u64  (.clk(clk), .rst(rst), .bus(b64));
    spoc_bdi_block_buffer #(.PW(32), .RATE(128)) u128 (.clk(clk), .rst(rst), .bus(b128));
    spoc_bdi_block_buffer #(.PW(8),  .RATE(64))  u8   (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        logic [127:0] blk;
        logic [127:0] mask;
        int           bytes;
        bit           partial;
    } exp_t;

    exp_t q64[$];
    exp_t q128[$];
    exp_t q8[$];

    localparam logic [63:0]  ONES64  = {64{1'b1}};
    localparam logic [127:0] ONES128 = {128{1'b1}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push(input int which, input logic [127:0] blk, input logic [127:0] mask,
                        input int bytes, input bit partial);
        exp_t e;
        e.blk = blk; e.mask = mask; e.bytes = bytes; e.partial = partial;
        case (which)
            0: q64.push_back(e);
            1: q128.push_back(e);
            default: q8.push_back(e);
        endcase
    endtask

    task automatic mon(input int which, input logic [127:0] blk, input logic [127:0] mask,
                       input int bytes, input bit partial);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (which)
            0: if (q64.size() > 0)  begin e = q64.pop_front();  have = 1'b1; end
            1: if (q128.size() > 0) begin e = q128.pop_front(); have = 1'b1; end
            default: if (q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_blk dut%0d: actual blk %h required no block", which, blk);
        end else begin
            chk($sformatf("dut%0d_blk", which), blk, e.blk);
            chk($sformatf("dut%0d_mask", which), mask, e.mask);
            chk($sformatf("dut%0d_bytes", which), 128'(bytes), 128'(e.bytes));
            chk($sformatf("dut%0d_partial", which), 128'(partial), 128'(e.partial));
            $display("[%0t] dut%0d block %h mask %h bytes %0d partial %0d",
                     $time, which, blk, mask, bytes, partial);
        end
    endtask

    // Monitors: one block handshake per pop, sampled on the falling edge.
    always @(negedge clk)
        if (!rst && b64.blk_valid && b64.blk_ready)
            mon(0, 128'(b64.blk), 128'(b64.blk_mask), int'(b64.blk_bytes), b64.blk_partial);
    always @(negedge clk)
        if (!rst && b128.blk_valid && b128.blk_ready)
            mon(1, 128'(b128.blk), 128'(b128.blk_mask), int'(b128.blk_bytes), b128.blk_partial);
    always @(negedge clk)
        if (!rst && b8.blk_valid && b8.blk_ready)
            mon(2, 128'(b8.blk), 128'(b8.blk_mask), int'(b8.blk_bytes), b8.blk_partial);

    // A zero-sized accepted word is illegal input.
    always @(posedge clk) begin
        if (!rst && b64.bdi_valid && b64.bdi_ready)
            assert (b64.bdi_size != '0) else $error("dut0 accepted bdi_size of zero");
        if (!rst && b128.bdi_valid && b128.bdi_ready)
            assert (b128.bdi_size != '0) else $error("dut1 accepted bdi_size of zero");
        if (!rst && b8.bdi_valid && b8.bdi_ready)
            assert (b8.bdi_size != '0) else $error("dut2 accepted bdi_size of zero");
    end

    function automatic bit rdy(input int which);
        case (which)
            0: return b64.bdi_ready;
            1: return b128.bdi_ready;
            default: return b8.bdi_ready;
        endcase
    endfunction

    // Called and returns at posedge+1; holds the word until it is accepted.
    task automatic send(input int which, input logic [31:0] w, input int sz, input bit eot);
        int n;
        n = 0;
        case (which)
            0: begin b64.bdi = w; b64.bdi_size = 3'(sz); b64.bdi_eot = eot; b64.bdi_valid = 1'b1; end
            1: begin b128.bdi = w; b128.bdi_size = 3'(sz); b128.bdi_eot = eot; b128.bdi_valid = 1'b1; end
            default: begin b8.bdi = w[7:0]; b8.bdi_size = 1'(sz); b8.bdi_eot = eot; b8.bdi_valid = 1'b1; end
        endcase
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(which) && n < 40);
        chk($sformatf("dut%0d_send_ready", which), 128'(rdy(which)), 128'(1));
        @(posedge clk); #1;
        case (which)
            0: begin b64.bdi_valid = 1'b0; b64.bdi_eot = 1'b0; end
            1: begin b128.bdi_valid = 1'b0; b128.bdi_eot = 1'b0; end
            default: begin b8.bdi_valid = 1'b0; b8.bdi_eot = 1'b0; end
        endcase
    endtask

    task automatic wait_ready(input int which);
        int n;
        n = 0;
        while (!rdy(which) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("dut%0d_wait_ready", which), 128'(rdy(which)), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b64.bdi = '0;  b64.bdi_valid = 1'b0;  b64.bdi_size = '0;  b64.bdi_eot = 1'b0;  b64.pad_empty = 1'b0;  b64.blk_ready = 1'b1;
        b128.bdi = '0; b128.bdi_valid = 1'b0; b128.bdi_size = '0; b128.bdi_eot = 1'b0; b128.pad_empty = 1'b0; b128.blk_ready = 1'b1;
        b8.bdi = '0;   b8.bdi_valid = 1'b0;   b8.bdi_size = '0;   b8.bdi_eot = 1'b0;   b8.pad_empty = 1'b0;   b8.blk_ready = 1'b1;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            chk("rst_bdi_ready", 128'(b64.bdi_ready), 128'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_blk_valid",   128'(b64.blk_valid), 128'(0));
        chk("rst_bdi_ready_1", 128'(b64.bdi_ready), 128'(1));
        chk("rst_blk",         128'(b64.blk), 128'(0));
        chk("rst_mask",        128'(b64.blk_mask), 128'(0));
        chk("rst_bytes",       128'(b64.blk_bytes), 128'(0));
        chk("rst_partial",     128'(b64.blk_partial), 128'(0));
        @(posedge clk); #1;

        // Full two-word block, then one HOLD cycle before refill
        push(0, 128'(64'h0011223344556677), 128'(ONES64), 8, 1'b0);
        send(0, 32'h00112233, 4, 1'b0);
        send(0, 32'h44556677, 4, 1'b1);
        @(negedge clk);
        chk("t1_blk_valid", 128'(b64.blk_valid), 128'(1));
        chk("t1_hold_ready", 128'(b64.bdi_ready), 128'(0));
        @(negedge clk);
        chk("t1_refill_ready", 128'(b64.bdi_ready), 128'(1));
        @(posedge clk); #1;

        // Short words: padding inside and just after the first slot
        push(0, 128'(64'hAABBCC8000000000), 128'(64'hFFFFFF0000000000), 3, 1'b1);
        send(0, 32'hAABBCCDD, 3, 1'b1);
        push(0, 128'(64'hAABBCCDD80000000), 128'(64'hFFFFFFFF00000000), 4, 1'b1);
        send(0, 32'hAABBCCDD, 4, 1'b1);

        // pad_empty when idle; ignored against a word and when idx != 0
        push(0, 128'(64'h8000000000000000), 128'(0), 0, 1'b1);
        wait_ready(0);
        b64.pad_empty = 1'b1;
        @(posedge clk); #1;
        b64.pad_empty = 1'b0;
        push(0, 128'(64'h123456789ABCDEF0), 128'(ONES64), 8, 1'b0);
        wait_ready(0);
        b64.pad_empty = 1'b1;
        send(0, 32'h12345678, 4, 1'b0);
        @(posedge clk); #1;
        b64.pad_empty = 1'b0;
        send(0, 32'h9ABCDEF0, 4, 1'b1);

        // Backpressure: a word waits while the block is held
        wait_ready(0);
        b64.blk_ready = 1'b0;
        push(0, 128'(64'hCAFEF00D0BADBEEF), 128'(ONES64), 8, 1'b0);
        send(0, 32'hCAFEF00D, 4, 1'b0);
        send(0, 32'h0BADBEEF, 4, 1'b1);
        b64.bdi = 32'h11111111; b64.bdi_size = 3'd4; b64.bdi_eot = 1'b1; b64.bdi_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_bdi_ready", 128'(b64.bdi_ready), 128'(0));
            chk("bp_blk_valid", 128'(b64.blk_valid), 128'(1));
            chk("bp_blk_stable", 128'(b64.blk), 128'(64'hCAFEF00D0BADBEEF));
            @(posedge clk); #1;
        end
        push(0, 128'(64'h1111111180000000), 128'(64'hFFFFFFFF00000000), 4, 1'b1);
        b64.blk_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_refill_ready", 128'(b64.bdi_ready), 128'(1));
        @(posedge clk); #1;
        b64.bdi_valid = 1'b0; b64.bdi_eot = 1'b0;

        // RATE=128: partial three-word block, then a full four-word block
        push(1, 128'h0102030405060708090A800000000000, 128'hFFFFFFFFFFFFFFFFFFFF000000000000, 10, 1'b1);
        send(1, 32'h01020304, 4, 1'b0);
        send(1, 32'h05060708, 4, 1'b0);
        send(1, 32'h090A0000, 2, 1'b1);
        push(1, 128'h101112131415161718191A1B1C1D1E1F, ONES128, 16, 1'b0);
        send(1, 32'h10111213, 4, 1'b0);
        send(1, 32'h14151617, 4, 1'b0);
        send(1, 32'h18191A1B, 4, 1'b0);
        send(1, 32'h1C1D1E1F, 4, 1'b0);

        // PW=8: eight bytes close on the last slot, then a single-byte eot block
        push(2, 128'(64'hA0A1A2A3A4A5A6A7), 128'(ONES64), 8, 1'b0);
        for (int i = 0; i < 8; i++) send(2, 32'hA0 + 32'(i), 1, 1'b0);
        push(2, 128'(64'h5A80000000000000), 128'(64'hFF00000000000000), 1, 1'b1);
        send(2, 32'h5A, 1, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Reset while holding a block
        b64.blk_ready = 1'b0;
        wait_ready(0);
        send(0, 32'h01020304, 2, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rh_blk_valid", 128'(b64.blk_valid), 128'(0));
        chk("rh_blk",       128'(b64.blk), 128'(0));
        chk("rh_bdi_ready", 128'(b64.bdi_ready), 128'(1));
        chk("rh_mask",      128'(b64.blk_mask), 128'(0));
        b64.blk_ready = 1'b1;
        @(posedge clk); #1;

        // Reset after one word of a block
        send(0, 32'h55555555, 4, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rf_blk_valid", 128'(b64.blk_valid), 128'(0));
        chk("rf_blk",       128'(b64.blk), 128'(0));
        chk("rf_bdi_ready", 128'(b64.bdi_ready), 128'(1));
        @(posedge clk); #1;

        push(0, 128'(64'hA1A2A3A4B1B28000), 128'(64'hFFFFFFFFFFFF0000), 6, 1'b1);
        send(0, 32'hA1A2A3A4, 4, 1'b0);
        send(0, 32'hB1B2B3B4, 2, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        chk("q64_drained",  128'(q64.size()), 128'(0));
        chk("q128_drained", 128'(q128.size()), 128'(0));
        chk("q8_drained",   128'(q8.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
